// File: rtl/rv_ctrl_decode_pkg.sv
// Shared encodings and the registered control word for the RV32I control decoder.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  // All-zero word doubles as the pipeline bubble.
  typedef struct packed {
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regwrite;
    logic       jump;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/rv_ctrl_decode_alu.sv
// Combinational ALU-control decoder driven by the main decoder's ALUOp.
import rv_ctrl_pkg::*;

module rv_alu_ctrl_dec (
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  aluop_t     ALUOp,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with instr[30] subtracts; addi keeps adding.
          3'b000:  ALUControl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_ctrl_decode.sv
// RV32I main decoder plus ALU decoder, registered at the ID/EX boundary.
import rv_ctrl_pkg::*;

module rv_ctrl_decode (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       flush,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [1:0] ResultSrc,
  output logic       MemWrite,
  output logic       Branch,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Jump,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  ctrl_t      dec;
  ctrl_t      nxt;
  ctrl_t      q;
  aluop_t     aluop;
  logic [2:0] aluctrl;

  always_comb begin
    dec   = '0;
    aluop = ALUOP_ADD;
    case (op)
      OP_LOAD: begin
        dec.regwrite  = 1'b1;
        dec.immsrc    = IMM_I;
        dec.alusrc    = 1'b1;
        dec.resultsrc = RES_MEM;
      end
      OP_STORE: begin
        dec.immsrc   = IMM_S;
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
      end
      OP_R: begin
        dec.regwrite = 1'b1;
        aluop        = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        dec.immsrc = IMM_B;
        dec.branch = 1'b1;
        aluop      = ALUOP_SUB;
      end
      OP_IALU: begin
        dec.regwrite = 1'b1;
        dec.immsrc   = IMM_I;
        dec.alusrc   = 1'b1;
        aluop        = ALUOP_FUNCT;
      end
      OP_JAL: begin
        dec.regwrite  = 1'b1;
        dec.immsrc    = IMM_J;
        dec.resultsrc = RES_PC4;
        dec.jump      = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  rv_alu_ctrl_dec u_alu_dec (
    .opb5       (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUOp      (aluop),
    .ALUControl (aluctrl)
  );

  always_comb begin
    nxt            = dec;
    nxt.alucontrol = aluctrl;
  end

  // Flush beats stall so a bubble can be inserted into a held stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= '0;
    else if (flush)
      q <= '0;
    else if (en)
      q <= nxt;
  end

  assign ResultSrc  = q.resultsrc;
  assign MemWrite   = q.memwrite;
  assign Branch     = q.branch;
  assign ALUSrc     = q.alusrc;
  assign RegWrite   = q.regwrite;
  assign Jump       = q.jump;
  assign ImmSrc     = q.immsrc;
  assign ALUControl = q.alucontrol;
  assign Illegal    = q.illegal;

endmodule

// File: tb/tb_rv_ctrl_decode.sv
// Directed self-checking bench for rv_ctrl_decode with hand-computed control words.
module tb_rv_ctrl_decode;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic [1:0] ResultSrc;
  logic       MemWrite;
  logic       Branch;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Jump;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       Illegal;

  int total = 0;
  int bad   = 0;

  rv_ctrl_decode dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .flush      (flush),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ResultSrc  (ResultSrc),
    .MemWrite   (MemWrite),
    .Branch     (Branch),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .Jump       (Jump),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  // Word order: ResultSrc, MemWrite, Branch, ALUSrc, RegWrite, Jump, ImmSrc, ALUControl, Illegal
  function automatic logic [12:0] word(input logic [1:0] rs, input logic mw, input logic br,
                                       input logic as, input logic rw, input logic j,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic ill);
    return {rs, mw, br, as, rw, j, imm, alu, ill};
  endfunction

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic e, input logic fl);
    @(negedge clk);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    en       = e;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [12:0] expected);
    logic [12:0] observed;
    observed = {ResultSrc, MemWrite, Branch, ALUSrc, RegWrite, Jump, ImmSrc, ALUControl, Illegal};
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      $error("[TB] %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held while inputs and clock toggle.
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b1, 1'b0);
    applyStimulus(7'b1101111, 3'b111, 1'b0, 1'b1, 1'b0);
    checkOutput("reset_hold", 13'b0);

    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b1, 1'b0);
    checkOutput("r_sub", word(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b001, 0));

    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b1, 1'b0);
    checkOutput("lw", word(2'b01, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0));
    applyStimulus(7'b0100011, 3'b010, 1'b1, 1'b1, 1'b0);
    checkOutput("sw", word(2'b00, 1, 0, 1, 0, 0, 2'b01, 3'b000, 0));
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0);
    checkOutput("beq", word(2'b00, 0, 1, 0, 0, 0, 2'b10, 3'b001, 0));
    applyStimulus(7'b1101111, 3'b110, 1'b1, 1'b1, 1'b0);
    checkOutput("jal", word(2'b10, 0, 0, 0, 1, 1, 2'b11, 3'b000, 0));

    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b1, 1'b0);
    checkOutput("r_add", word(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b000, 0));
    applyStimulus(7'b0110011, 3'b010, 1'b0, 1'b1, 1'b0);
    checkOutput("r_slt", word(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b101, 0));
    applyStimulus(7'b0110011, 3'b110, 1'b0, 1'b1, 1'b0);
    checkOutput("r_or", word(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b011, 0));
    applyStimulus(7'b0110011, 3'b111, 1'b1, 1'b1, 1'b0);
    checkOutput("r_and", word(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b010, 0));
    applyStimulus(7'b0110011, 3'b001, 1'b1, 1'b1, 1'b0);
    checkOutput("r_other_f3", word(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b000, 0));
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b1, 1'b0);
    checkOutput("addi_f7b5", word(2'b00, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0));
    applyStimulus(7'b0010011, 3'b010, 1'b0, 1'b1, 1'b0);
    checkOutput("slti", word(2'b00, 0, 0, 1, 1, 0, 2'b00, 3'b101, 0));

    applyStimulus(7'b1110011, 3'b000, 1'b1, 1'b1, 1'b0);
    checkOutput("illegal", word(2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1));

    // Stall holds lw while sw is presented, then flush beats the stall.
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b1, 1'b0);
    checkOutput("lw_load", word(2'b01, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0));
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_hold", word(2'b01, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0));
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_stalled", 13'b0);
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b0);
    checkOutput("jal_after_flush", word(2'b10, 0, 0, 0, 1, 1, 2'b11, 3'b000, 0));
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_enabled", 13'b0);

    // Asynchronous reset between edges while holding an R-type word.
    applyStimulus(7'b0110011, 3'b110, 1'b0, 1'b1, 1'b0);
    checkOutput("r_before_async", word(2'b00, 0, 0, 0, 1, 0, 2'b00, 3'b011, 0));
    en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 13'b0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
